// File: rtl/mem_port_arbiter_if.sv
// Request, grant, read-return and BRAM signals shared by the CPU port, the
// debug port and the memory behind the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_addr,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus the memory.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_addr,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter between the CPU control unit and the debug/readout
// port, with bounded debug starvation and owner-tagged read returns.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic top_en,
    mem_port_arbiter_if.slave bus
);
    logic [3:0]        starve_cnt;
    logic              starved;
    logic              dbg_wins;
    logic              cpu_gnt;
    logic              dbg_gnt;
    logic              rd_gnt;
    logic [RD_LAT-1:0] tag_vld_p;
    logic [RD_LAT-1:0] tag_dbg_p;
    logic              ret_vld;
    logic              ret_dbg;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic [DATA_W-1:0] cpu_rdata_hold;
    logic [DATA_W-1:0] dbg_rdata_hold;

    // Arbitration: debug owns the port while the CPU is halted or once it has starved.
    assign starved  = (starve_cnt == 4'(STARVE_MAX));
    assign dbg_wins = bus.dbg_req & (~top_en | starved);
    assign cpu_gnt  = ~rst & top_en & bus.cpu_req & ~dbg_wins;
    assign dbg_gnt  = ~rst & bus.dbg_req & ~cpu_gnt;
    assign rd_gnt   = dbg_gnt | (cpu_gnt & ~bus.cpu_we);

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dbg_gnt   = dbg_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (bus.dbg_req & ~dbg_gnt) begin
            starve_cnt <= starved ? starve_cnt : starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // Memory request stage: address/data hold their last value when idle.
    assign bus.mem_en    = cpu_gnt | dbg_gnt;
    assign bus.mem_we    = cpu_gnt & bus.cpu_we;
    assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr : (dbg_gnt ? bus.dbg_addr : addr_hold);
    assign bus.mem_wdata = cpu_gnt ? bus.cpu_wdata : wdata_hold;

    always_ff @(posedge clk) begin
        addr_hold  <= bus.mem_addr;
        wdata_hold <= bus.mem_wdata;
    end

    // Tag pipeline stages _p0.._p(RD_LAT-1): tracks reads in flight inside the BRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= rd_gnt;
            for (int i = 1; i < RD_LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_dbg_p[0] <= dbg_gnt;
        for (int i = 1; i < RD_LAT; i++) tag_dbg_p[i] <= tag_dbg_p[i-1];
    end

    // Return stage: the owner's rdata passes mem_rdata on its pulse, otherwise holds.
    assign ret_vld = tag_vld_p[RD_LAT-1] & ~rst;
    assign ret_dbg = tag_dbg_p[RD_LAT-1];

    assign bus.cpu_rvalid = ret_vld & ~ret_dbg;
    assign bus.dbg_rvalid = ret_vld & ret_dbg;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : cpu_rdata_hold;
    assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : dbg_rdata_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_hold <= '0;
            dbg_rdata_hold <= '0;
        end else begin
            if (bus.cpu_rvalid) cpu_rdata_hold <= bus.mem_rdata;
            if (bus.dbg_rvalid) dbg_rdata_hold <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (read latency 1 and 2) with identical requests and checks
// grants, memory strobes and read returns against a shadow-memory model.
module tb_mem_port_arbiter;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst, top_en;
    logic cpu_req, cpu_we, dbg_req;
    logic [15:0] cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) ifc1 ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) ifc2 ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(SM)) dut1 (
        .clk(clk), .rst(rst), .top_en(top_en), .bus(ifc1));
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(SM)) dut2 (
        .clk(clk), .rst(rst), .top_en(top_en), .bus(ifc2));

    always #5 clk = ~clk;

    assign ifc1.cpu_req = cpu_req;   assign ifc2.cpu_req = cpu_req;
    assign ifc1.cpu_we = cpu_we;     assign ifc2.cpu_we = cpu_we;
    assign ifc1.cpu_addr = cpu_addr; assign ifc2.cpu_addr = cpu_addr;
    assign ifc1.cpu_wdata = cpu_wdata; assign ifc2.cpu_wdata = cpu_wdata;
    assign ifc1.dbg_req = dbg_req;   assign ifc2.dbg_req = dbg_req;
    assign ifc1.dbg_addr = dbg_addr; assign ifc2.dbg_addr = dbg_addr;

    function automatic logic [31:0] init_val(input int a);
        return (a == 16'h0010) ? 32'hDEADBEEF : (32'hC0FF_EE00 | 32'(a));
    endfunction

    // Write-first BRAM shared by both arbiters; each gets its own read delay line.
    logic [31:0] mem_arr [256];
    logic [31:0] rd1, rd2a, rd2b;
    bit init_done;
    assign ifc1.mem_rdata = rd1;
    assign ifc2.mem_rdata = rd2b;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (ifc1.mem_en && ifc1.mem_we) begin
            mem_arr[ifc1.mem_addr[7:0]] <= ifc1.mem_wdata;
        end
        if (ifc1.mem_en && !ifc1.mem_we) rd1 <= mem_arr[ifc1.mem_addr[7:0]];
        if (ifc2.mem_en && !ifc2.mem_we) rd2a <= mem_arr[ifc2.mem_addr[7:0]];
        rd2b <= rd2a;
    end

    typedef struct { int due; bit dbg; logic [31:0] data; } ret_t;
    typedef struct { bit te, cr, cw, dr, ecg, edg; } vec_t;

    ret_t q1[$];
    ret_t q2[$];
    logic [31:0] shadow [256];
    logic [31:0] exp_cd [2];
    logic [31:0] exp_dd [2];
    logic [15:0] exp_addr_hold;
    bit have_addr;
    int denied, cyc_n, n_chk, n_fail;
    bit last_cg, last_dg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic chk_ret(input int k, input bit has, input ret_t h, input logic cv, input logic dv,
                           input logic [31:0] cd, input logic [31:0] dd);
        if (has && !h.dbg) exp_cd[k] = h.data;
        if (has && h.dbg) exp_dd[k] = h.data;
        chk($sformatf("dut%0d cpu_rvalid", k + 1), 64'(cv), 64'(has && !h.dbg));
        chk($sformatf("dut%0d dbg_rvalid", k + 1), 64'(dv), 64'(has && h.dbg));
        if (!rst) begin
            chk($sformatf("dut%0d cpu_rdata", k + 1), 64'(cd), 64'(exp_cd[k]));
            chk($sformatf("dut%0d dbg_rdata", k + 1), 64'(dd), 64'(exp_dd[k]));
        end
    endtask

    // One clock cycle: entered at posedge+1 with inputs set, checks at negedge, advances model.
    task automatic cyc(input bit tc, input bit tcg, input bit tdg);
        bit ecg, edg, h1, h2;
        ret_t e1, e2, nr;
        logic [15:0] ea;
        @(negedge clk);
        ecg = 1'b0;
        edg = 1'b0;
        if (!rst) begin
            if (!top_en) edg = dbg_req;
            else if (dbg_req && denied == SM) edg = 1'b1;
            else if (cpu_req) ecg = 1'b1;
            else edg = dbg_req;
        end
        ea = ecg ? cpu_addr : (edg ? dbg_addr : exp_addr_hold);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d cpu_gnt", k + 1), 64'(k ? ifc2.cpu_gnt : ifc1.cpu_gnt), 64'(ecg));
            chk($sformatf("dut%0d dbg_gnt", k + 1), 64'(k ? ifc2.dbg_gnt : ifc1.dbg_gnt), 64'(edg));
            chk($sformatf("dut%0d cpu_stall", k + 1), 64'(k ? ifc2.cpu_stall : ifc1.cpu_stall),
                64'(cpu_req && !ecg));
            chk($sformatf("dut%0d mem_en", k + 1), 64'(k ? ifc2.mem_en : ifc1.mem_en), 64'(ecg || edg));
            chk($sformatf("dut%0d mem_we", k + 1), 64'(k ? ifc2.mem_we : ifc1.mem_we), 64'(ecg && cpu_we));
            if (ecg || edg || have_addr)
                chk($sformatf("dut%0d mem_addr", k + 1), 64'(k ? ifc2.mem_addr : ifc1.mem_addr), 64'(ea));
            if (ecg && cpu_we)
                chk($sformatf("dut%0d mem_wdata", k + 1), 64'(k ? ifc2.mem_wdata : ifc1.mem_wdata),
                    64'(cpu_wdata));
        end
        if (tc) begin
            chk("tbl cpu_gnt", 64'(ifc1.cpu_gnt), 64'(tcg));
            chk("tbl dbg_gnt", 64'(ifc1.dbg_gnt), 64'(tdg));
        end
        h1 = !rst && q1.size() > 0 && q1[0].due == cyc_n;
        h2 = !rst && q2.size() > 0 && q2[0].due == cyc_n;
        e1 = h1 ? q1[0] : '{0, 1'b0, 32'h0};
        e2 = h2 ? q2[0] : '{0, 1'b0, 32'h0};
        chk_ret(0, h1, e1, ifc1.cpu_rvalid, ifc1.dbg_rvalid, ifc1.cpu_rdata, ifc1.dbg_rdata);
        chk_ret(1, h2, e2, ifc2.cpu_rvalid, ifc2.dbg_rvalid, ifc2.cpu_rdata, ifc2.dbg_rdata);

        if (rst) begin
            denied = 0;
            q1.delete();
            q2.delete();
            exp_cd = '{32'h0, 32'h0};
            exp_dd = '{32'h0, 32'h0};
        end else begin
            if (h1) void'(q1.pop_front());
            if (h2) void'(q2.pop_front());
            if ((ecg && !cpu_we) || edg) begin
                nr.dbg = edg;
                nr.data = shadow[ea[7:0]];
                nr.due = cyc_n + 1;
                q1.push_back(nr);
                nr.due = cyc_n + 2;
                q2.push_back(nr);
            end
            if (ecg && cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata;
            if (dbg_req && !edg) denied = (denied < SM) ? denied + 1 : SM;
            else denied = 0;
        end
        if (ecg || edg) begin
            exp_addr_hold = ea;
            have_addr = 1'b1;
        end
        last_cg = ecg;
        last_dg = edg;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [17];

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        exp_cd = '{32'h0, 32'h0};
        exp_dd = '{32'h0, 32'h0};
        rst = 1'b1; top_en = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003; cpu_wdata = 32'h0;
        dbg_req = 1'b1; dbg_addr = 16'h0005;
        #1;

        // Reset with both ports requesting: nothing granted or returned.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // Arbitration table starting from a cleared starvation counter.
        tbl[0]  = '{1, 1, 0, 1, 1, 0}; tbl[1]  = '{1, 1, 0, 1, 1, 0};
        tbl[2]  = '{1, 1, 0, 1, 1, 0}; tbl[3]  = '{1, 1, 0, 1, 1, 0};
        tbl[4]  = '{1, 1, 0, 1, 0, 1}; tbl[5]  = '{1, 1, 0, 1, 1, 0};
        tbl[6]  = '{1, 1, 0, 1, 1, 0}; tbl[7]  = '{1, 1, 0, 1, 1, 0};
        tbl[8]  = '{1, 1, 0, 1, 1, 0}; tbl[9]  = '{1, 1, 0, 1, 0, 1};
        tbl[10] = '{0, 1, 0, 1, 0, 1}; tbl[11] = '{0, 1, 0, 1, 0, 1};
        tbl[12] = '{0, 1, 0, 0, 0, 0}; tbl[13] = '{1, 1, 0, 0, 1, 0};
        tbl[14] = '{1, 0, 0, 1, 0, 1}; tbl[15] = '{1, 0, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 1, 0, 1, 0};
        cpu_wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 17; i++) begin
            top_en = tbl[i].te; cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; dbg_req = tbl[i].dr;
            cyc(1'b1, tbl[i].ecg, tbl[i].edg);
        end
        cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0; top_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // CPU read of a preloaded word.
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        cyc(1'b0, 1'b0, 1'b0);
        cpu_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("preload cpu_rdata dut1", 64'(ifc1.cpu_rdata), 64'h0000_0000_DEAD_BEEF);
        chk("preload cpu_rdata dut2", 64'(ifc2.cpu_rdata), 64'h0000_0000_DEAD_BEEF);

        // CPU write immediately followed by a debug read of the same word.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'h12345678;
        cyc(1'b0, 1'b0, 1'b0);
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b1; dbg_addr = 16'h0020;
        cyc(1'b0, 1'b0, 1'b0);
        dbg_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("raw dbg_rdata dut1", 64'(ifc1.dbg_rdata), 64'h0000_0000_1234_5678);
        chk("raw dbg_rdata dut2", 64'(ifc2.dbg_rdata), 64'h0000_0000_1234_5678);

        // Reset while a read is in flight drops its return.
        cpu_req = 1'b1; cpu_addr = 16'h0007;
        cyc(1'b0, 1'b0, 1'b0);
        cpu_req = 1'b0; rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk("flush cpu_rvalid dut2", 64'(ifc2.cpu_rvalid), 64'h0);
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        cyc(1'b0, 1'b0, 1'b0);
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);

        // Randomized traffic; requesters hold each request until granted.
        for (int i = 0; i < 600; i++) begin
            if (!cpu_req || last_cg) begin
                cpu_req = ($urandom % 4) != 0;
                cpu_we = ($urandom % 3) == 0;
                cpu_addr = 16'($urandom % 16);
                cpu_wdata = $urandom;
            end
            if (!dbg_req || last_dg) begin
                dbg_req = ($urandom % 2) != 0;
                dbg_addr = 16'($urandom % 16);
            end
            top_en = ($urandom % 10) != 0;
            rst = ($urandom % 60) == 0;
            cyc(1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
